crc_attach_ctrl: RTL

CRC_ATTACH_CTRL -- requirements
Module: crc_attach_ctrl

---
 rtl/crc_attach_ctrl_pkg.sv | 17 +
 rtl/crc_attach_ctrl_crc24.sv | 40 ++++
 rtl/crc_attach_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/crc_attach_ctrl_pkg.sv
// Shared definitions for the CRC24 attach controller: FSM states, CRC width
// and the CRC24A generator polynomial (implicit x^24 term omitted).
package crc_attach_ctrl_pkg;

  localparam int CRC_W     = 24;
  localparam int CRC_CNT_W = 5;
  localparam logic [CRC_W-1:0]     CRC_POLY  = 24'h864CFB;
  localparam logic [CRC_CNT_W-1:0] CRC_BEATS = 5'd24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/crc_attach_ctrl_crc24.sv
// Serial MSB-first CRC24A LFSR.
// init clears the register, en_com clocks one message bit (d_in) into the
// CRC, nen_shift low shifts the register left with zero fill (used to
// stream the remainder out). init > en_com > shift; otherwise hold.
module crc_attach_ctrl_crc24
  import crc_attach_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             init,
  input  logic             en_com,
  input  logic             d_in,
  input  logic             nen_shift,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] crc_next;
  logic             feedback;

  // Next-state of the LFSR for the selected operation
  always_comb begin
    feedback = crc_reg[CRC_W-1] ^ d_in;
    crc_next = crc_reg;
    if (init) begin
      crc_next = '0;
    end else if (en_com) begin
      crc_next = {crc_reg[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
    end else if (!nen_shift) begin
      crc_next = {crc_reg[CRC_W-2:0], 1'b0};
    end
  end

  // Register update
  always_ff @(posedge clk) begin
    crc_reg <= crc_next;
  end

  assign crc = crc_reg;

endmodule

// File: rtl/crc_attach_ctrl.sv
// CRC24A attach controller: forwards a serial payload of blk_len bits and
// appends its 24-bit CRC24A, MSB first.
// Optional macro CRC_ATTACH_CHECK_EN adds a check mode (ports check/crc_ok)
// in which the trailing 24 input bits are absorbed and verified instead of
// a CRC being appended. In check mode the CRC state acts as the absorb phase.
module crc_attach_ctrl
  import crc_attach_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] blk_len,
`ifdef CRC_ATTACH_CHECK_EN
  input  logic             check,
  output logic             crc_ok,
`endif
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic             m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             done
);

  state_t                state_reg;
  logic [LEN_W-1:0]      len_cnt_reg;
  logic [CRC_CNT_W-1:0]  crc_cnt_reg;
  logic [CRC_W-1:0]      crc;
  logic                  check_mode;
  logic                  start_ok;
  logic                  in_data;
  logic                  in_crc;
  logic                  data_beat;
  logic                  absorb_beat;
  logic                  out_beat;

  assign start_ok    = (state_reg == IDLE) && start;
  assign in_data     = (state_reg == DATA);
  assign in_crc      = (state_reg == CRC);
  assign data_beat   = in_data && s_valid && m_ready;
  assign absorb_beat = in_crc && check_mode && s_valid;
  assign out_beat    = in_crc && !check_mode && m_ready;

  // Stream handshakes: payload passes straight through in DATA, the CRC
  // phase either drives the remainder out or absorbs the received CRC
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = 1'b0;
    m_last  = 1'b0;
    if (in_data) begin
      s_ready = m_ready;
      m_valid = s_valid;
      m_data  = s_data;
      m_last  = check_mode && (len_cnt_reg == LEN_W'(1));
    end else if (in_crc) begin
      if (check_mode) begin
        s_ready = 1'b1;
      end else begin
        m_valid = 1'b1;
        m_data  = crc[CRC_W-1];
        m_last  = (crc_cnt_reg == CRC_CNT_W'(1));
      end
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

  // Control FSM with payload and CRC beat counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      len_cnt_reg <= '0;
      crc_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_cnt_reg <= blk_len;
            crc_cnt_reg <= CRC_BEATS;
            state_reg   <= (blk_len == '0) ? CRC : DATA;
          end
        end
        DATA: begin
          if (data_beat) begin
            len_cnt_reg <= len_cnt_reg - 1'b1;
            if (len_cnt_reg == LEN_W'(1)) state_reg <= CRC;
          end
        end
        CRC: begin
          if (absorb_beat || out_beat) begin
            crc_cnt_reg <= crc_cnt_reg - 1'b1;
            if (crc_cnt_reg == CRC_CNT_W'(1)) state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef CRC_ATTACH_CHECK_EN
  logic check_mode_reg;
  logic crc_ok_reg;

  // Mode captured with start; verdict latched in DONE and held until next start
  always_ff @(posedge clk) begin
    if (reset) begin
      check_mode_reg <= 1'b0;
      crc_ok_reg     <= 1'b0;
    end else if (start_ok) begin
      check_mode_reg <= check;
      crc_ok_reg     <= 1'b0;
    end else if (state_reg == DONE) begin
      crc_ok_reg     <= check_mode_reg && (crc == '0);
    end
  end

  assign check_mode = check_mode_reg;
  assign crc_ok     = (state_reg == DONE) ? (check_mode_reg && (crc == '0)) : crc_ok_reg;
`else
  assign check_mode = 1'b0;
  logic unused_crc_bits;
  assign unused_crc_bits = &{1'b0, crc[CRC_W-2:0]};
`endif

  crc_attach_ctrl_crc24 u_crc24 (
    .clk       (clk),
    .init      (reset || start_ok),
    .en_com    (data_beat || absorb_beat),
    .d_in      (s_data),
    .nen_shift (!out_beat),
    .crc       (crc)
  );

endmodule
